// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the requesters, the downstream consumer and
// the selector arbiter. The master side drives requests and ready; the
// slave side (the arbiter) returns the registered selection.
interface mux_sel_arbiter_if;
  logic [30:0] req;
  logic        ready;
  logic [4:0]  sel;
  logic        sel_valid;
  logic        busy;

  modport master (
    output req,
    output ready,
    input  sel,
    input  sel_valid,
    input  busy
  );

  modport slave (
    input  req,
    input  ready,
    output sel,
    output sel_valid,
    output busy
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select input of a 31:1 selector.
// A grant is loaded into sel, optionally left to settle for SETTLE cycles,
// and then offered with sel_valid until the consumer accepts it with ready.
module mux_sel_arbiter #(
  parameter int SETTLE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_sel_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OFFER  = 2'd2
  } state_t;

  // Last count value of the settle window; unused when SETTLE is 0.
  localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [4:0]  sel_q, sel_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_valid_q, sel_valid_d;
  logic        busy_q, busy_d;
  logic [4:0]  ptr_after_accept;

  // First set request at or above p, wrapping 30 -> 0; returns p if none.
  function automatic logic [4:0] rr_pick(input logic [30:0] r, input logic [4:0] p);
    logic [4:0] res;
    logic       found;
    logic [5:0] idx;
    res   = p;
    found = 1'b0;
    for (int k = 0; k < 31; k++) begin
      idx = {1'b0, p} + 6'(k);
      if (idx >= 6'd31) idx = idx - 6'd31;
      if (!found && r[idx[4:0]]) begin
        res   = idx[4:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign ptr_after_accept = (sel_q == 5'd30) ? 5'd0 : sel_q + 5'd1;

  // State and datapath registers; reset clears everything asynchronously,
  // so an in-flight grant disappears the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= 5'd0;
      ptr_q       <= 5'd0;
      cnt_q       <= 4'd0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic: grant selection, settle counting and accept handling.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          sel_d   = rr_pick(bus.req, ptr_q);
          cnt_d   = 4'd0;
          state_d = (SETTLE > 0) ? S_SETTLE : S_OFFER;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_OFFER;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_OFFER: begin
        // Requests dropping here never retract sel; only an accept moves on.
        if (bus.ready) begin
          ptr_d = ptr_after_accept;
          if (|bus.req) begin
            sel_d   = rr_pick(bus.req, ptr_after_accept);
            cnt_d   = 4'd0;
            state_d = (SETTLE > 0) ? S_SETTLE : S_OFFER;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs follow the state being entered on the next edge.
  always_comb begin
    sel_valid_d = (state_d == S_OFFER);
    busy_d      = (state_d != S_IDLE);
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: one instance with SETTLE=0 and one with SETTLE=3
// share the same requests and ready; a grant-level model is compared against
// both on every falling clock edge, with directed literal checks on top.
module tb_mux_sel_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [30:0] req_t = '0;
  logic        ready_t = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter_if if0 ();
  mux_sel_arbiter_if if3 ();

  assign if0.req   = req_t;
  assign if0.ready = ready_t;
  assign if3.req   = req_t;
  assign if3.ready = ready_t;

  mux_sel_arbiter #(.SETTLE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mux_sel_arbiter #(.SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  // Grant-level model: a grant is either absent or present with a number of
  // settle cycles still to wait; it is offered once that wait reaches zero.
  typedef struct {
    int busy;
    int wait_left;
    int sel;
    int ptr;
  } mdl_t;

  mdl_t m[2];
  int   settle_of[2] = '{0, 3};

  function automatic int mpick(logic [30:0] r, int p);
    for (int k = 0; k < 31; k++) begin
      if (r[(p + k) % 31]) return (p + k) % 31;
    end
    return p;
  endfunction

  function automatic mdl_t mstep(mdl_t cur, logic [30:0] r, logic rdy, int s);
    mdl_t n;
    n = cur;
    if (cur.busy == 0) begin
      if (r != 0) begin
        n.sel = mpick(r, cur.ptr);
        n.busy = 1;
        n.wait_left = s;
      end
    end else if (cur.wait_left > 0) begin
      n.wait_left = cur.wait_left - 1;
    end else if (rdy) begin
      n.ptr = (cur.sel + 1) % 31;
      if (r != 0) begin
        n.sel = mpick(r, n.ptr);
        n.wait_left = s;
      end else begin
        n.busy = 0;
      end
    end
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t z;
    z.busy = 0; z.wait_left = 0; z.sel = 0; z.ptr = 0;
    return z;
  endfunction

  // Model update on the same edges as the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mreset();
      m[1] <= mreset();
    end else begin
      m[0] <= mstep(m[0], req_t, ready_t, settle_of[0]);
      m[1] <= mstep(m[1], req_t, ready_t, settle_of[1]);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("u0.sel", int'(if0.sel), m[0].sel);
    chk("u0.sel_valid", int'(if0.sel_valid), (m[0].busy != 0 && m[0].wait_left == 0) ? 1 : 0);
    chk("u0.busy", int'(if0.busy), m[0].busy);
    chk("u3.sel", int'(if3.sel), m[1].sel);
    chk("u3.sel_valid", int'(if3.sel_valid), (m[1].busy != 0 && m[1].wait_left == 0) ? 1 : 0);
    chk("u3.busy", int'(if3.busy), m[1].busy);
    chk("u0.sel_not_31", (if0.sel == 5'd31) ? 1 : 0, 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req_t   = '0;
    ready_t = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    rst_n = 1'b0;
    tick();
    chk("rst.u0.sel", int'(if0.sel), 0);
    chk("rst.u0.sel_valid", int'(if0.sel_valid), 0);
    chk("rst.u0.busy", int'(if0.busy), 0);
    chk("rst.u3.busy", int'(if3.busy), 0);
    rst_n = 1'b1;

    // Single persistent requester on channel 5
    req_t = 31'(1) << 5;
    ready_t = 1'b1;
    tick();
    chk("one.first.sel", int'(if0.sel), 5);
    chk("one.first.valid", int'(if0.sel_valid), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("one.again.sel", int'(if0.sel), 5);
      chk("one.again.valid", int'(if0.sel_valid), 1);
    end

    // Three requesters, no bubble
    do_reset();
    req_t = (31'(1) << 3) | (31'(1) << 17) | (31'(1) << 30);
    ready_t = 1'b1;
    begin
      int exp_seq[6] = '{3, 17, 30, 3, 17, 30};
      for (int i = 0; i < 6; i++) begin
        tick();
        chk("rr3.sel", int'(if0.sel), exp_seq[i]);
        chk("rr3.valid", int'(if0.sel_valid), 1);
      end
    end

    // SETTLE=3 latency on channel 0
    do_reset();
    req_t = 31'(1);
    ready_t = 1'b0;
    tick();
    chk("settle.sel", int'(if3.sel), 0);
    chk("settle.busy", int'(if3.busy), 1);
    chk("settle.valid1", int'(if3.sel_valid), 0);
    tick();
    chk("settle.valid2", int'(if3.sel_valid), 0);
    tick();
    chk("settle.valid3", int'(if3.sel_valid), 0);
    tick();
    chk("settle.valid4", int'(if3.sel_valid), 1);

    // Held offer with request withdrawn
    do_reset();
    req_t = 31'(1) << 12;
    ready_t = 1'b0;
    tick();
    req_t = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold.sel", int'(if0.sel), 12);
      chk("hold.valid", int'(if0.sel_valid), 1);
    end
    ready_t = 1'b1;
    tick();
    chk("hold.after.valid", int'(if0.sel_valid), 0);
    chk("hold.after.busy", int'(if0.busy), 0);
    ready_t = 1'b0;

    // Pointer wrap from 29
    do_reset();
    req_t = 31'(1) << 28;
    ready_t = 1'b0;
    tick();
    chk("wrap.pre.sel", int'(if0.sel), 28);
    req_t = (31'(1) << 1) | (31'(1) << 30);
    ready_t = 1'b1;
    tick();
    chk("wrap.first", int'(if0.sel), 30);
    tick();
    chk("wrap.second", int'(if0.sel), 1);

    // Asynchronous reset mid-offer
    do_reset();
    req_t = 31'(1) << 20;
    ready_t = 1'b0;
    tick();
    chk("arst.pre.sel", int'(if0.sel), 20);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.valid", int'(if0.sel_valid), 0);
    chk("arst.sel", int'(if0.sel), 0);
    chk("arst.busy", int'(if0.busy), 0);
    tick();
    rst_n = 1'b1;
    req_t = (31'(1) << 20) | (31'(1) << 2);
    tick();
    chk("arst.after.sel", int'(if0.sel), 2);

    // Randomized traffic, checked by the per-cycle compare
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: req_t = '0;
          1: req_t = 31'(1) << $urandom_range(0, 30);
          2: req_t = (31'(1) << $urandom_range(0, 30)) | (31'(1) << $urandom_range(0, 30));
          default: req_t = 31'($urandom);
        endcase
      end
      ready_t = ($urandom_range(0, 2) != 0);
      tick();
    end

    req_t = '0;
    ready_t = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
